// File: rtl/punc_mem_responder.sv
// ----------------------------------------------------------------------------
// punc_mem_responder
//
// Memory-side responder for the PUnC LC3 core's memory port. It services one
// 16-bit read or write at a time over a req/ack handshake. Each access takes a
// fixed number of wait states. An access beyond DEPTH completes with err
// instead of touching memory. A separate registered debug port reads memory
// every cycle for the load/inspect harness.
//
// Parameters:
//   DEPTH        number of 16-bit words implemented (power of two, 2..65536)
//   WAIT_STATES  extra cycles inserted before each access completes (0..15)
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       access request
//   we        1 = write, 0 = read (sampled with req)
//   addr      word address (sampled with req)
//   wdata     write data (sampled with req)
//   ack       one-cycle completion pulse
//   rdata     read result, valid with ack on a read, held until the next read
//   err       address out of range, valid only with ack
//   busy      request in progress (WAIT or RESP)
//   dbg_addr  debug read address
//   dbg_data  registered debug read data (0 when dbg_addr is out of range)
//
// Handshake: a request is accepted on any rising edge in IDLE with req=1.
// we/addr/wdata are latched at that edge, and input changes while busy=1 are
// ignored. ack pulses for exactly one cycle WAIT_STATES+1 edges after the
// accept. The requester drops req in the cycle after ack. If req is still
// high on the first IDLE edge, that edge accepts a new request.
// ----------------------------------------------------------------------------
module punc_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy,
    input  logic [15:0] dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;

    logic [15:0] mem [DEPTH];

    logic          lat_in_range;
    logic          dbg_in_range;
    logic [AW-1:0] lat_idx;
    logic [AW-1:0] dbg_idx;
    logic          commit;

    // Compare in 17 bits so that DEPTH=65536 does not wrap the limit to zero.
    assign lat_in_range = ({1'b0, lat_addr} < 17'(DEPTH));
    assign dbg_in_range = ({1'b0, dbg_addr} < 17'(DEPTH));
    assign lat_idx      = lat_addr[AW-1:0];
    assign dbg_idx      = dbg_addr[AW-1:0];

    // The access happens on the edge that leaves WAIT with the counter at 0.
    // Reset forces the state to IDLE asynchronously, so an abandoned write
    // can never reach this point.
    assign commit = (state == WAIT) && (cnt == 4'd0);

    // The array has no reset, so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (commit && lat_we && lat_in_range) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 16'd0;
            lat_wdata <= 16'd0;
            ack       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            rdata     <= 16'd0;
            dbg_data  <= 16'd0;
        end else begin
            // The debug port samples the array before any write on this edge
            // lands, so a same-address write shows up one edge later.
            dbg_data <= dbg_in_range ? mem[dbg_idx] : 16'd0;

            case (state)
                IDLE: begin
                    if (req) begin
                        lat_we    <= we;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        cnt       <= 4'(WAIT_STATES);
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ack <= 1'b1;
                        err <= ~lat_in_range;
                        if (!lat_we) begin
                            rdata <= lat_in_range ? mem[lat_idx] : 16'd0;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    // req is deliberately not sampled here.
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
